alu_rs: RTL and testbench

- Reservation station in front of the integer ALU execute stage.
- Buffers up to DEPTH dispatched ALU instructions and captures operands from the common data bus (CDB) as their producer tags resolve.
- Issues at most one fully-ready instruction per cycle, oldest first, so the ALU only ever sees operands whose tags are `UNLOCKED.
- Issue outputs are registered and drive the ALU busy/op/data inputs directly. The ALU tag-x/y/w inputs are tied to `UNLOCKED at the top level.

---
 rtl/alu_rs_pkg.sv | 32 +++
 rtl/alu_rs_age.sv | 48 ++++
 rtl/alu_rs.sv | 147 ++++++++++++++
 tb/tb_alu_rs.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_rs_pkg.sv
// Shared types and constants for the ALU reservation station: instruction
// encoding, register tags, data words and the station entry payload.
package alu_rs_pkg;

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
    OP_SLL, OP_SRL, OP_SRA, OP_SLT, OP_SLTU
  } sinst_t;

  typedef logic [3:0]  regtag_t;
  typedef logic [31:0] word_t;
  typedef logic [4:0]  regaddr_t;

  // Tag value meaning "operand value is present, no producer outstanding"
  localparam regtag_t UNLOCKED = '0;
  localparam int      RS_DEPTH = 4;

  typedef struct packed {
    sinst_t   op;
    regtag_t  tagx;
    regtag_t  tagy;
    word_t    datax;
    word_t    datay;
    regtag_t  dest;
    regaddr_t target;
  } entry_t;

  function automatic logic operands_ready(input entry_t e);
    return (e.tagx == UNLOCKED) && (e.tagy == UNLOCKED);
  endfunction

endpackage

// File: rtl/alu_rs_age.sv
// Age matrix for the reservation station: tracks relative dispatch order of
// live entries and grants the oldest ready one (one-hot).
module alu_rs_age
  import alu_rs_pkg::*;
#(
  parameter int DEPTH = RS_DEPTH
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [DEPTH-1:0] alloc,
  input  logic [DEPTH-1:0] free,
  input  logic [DEPTH-1:0] ready,
  output logic [DEPTH-1:0] grant
);

  // older[i][j] set means entry i was dispatched before entry j
  logic [DEPTH-1:0] older [DEPTH];

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every read in this block sees the pre-edge value regardless of order.
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) older[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        for (int j = 0; j < DEPTH; j++) begin
          if (alloc[i] || free[i] || free[j]) begin
            older[i][j] <= 1'b0;
          end else if (alloc[j] && (i != j)) begin
            older[i][j] <= 1'b1;
          end
        end
      end
    end
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    grant = '0;
    for (int i = 0; i < DEPTH; i++) begin
      grant[i] = ready[i];
      for (int j = 0; j < DEPTH; j++) begin
        if ((j != i) && ready[j] && older[j][i]) grant[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_rs.sv
// Reservation station in front of the integer ALU: buffers dispatched
// instructions, captures CDB results and issues the oldest ready entry.
module alu_rs
  import alu_rs_pkg::*;
#(
  parameter int DEPTH = RS_DEPTH,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic           clk_in,
  input  logic           rst_in,
  input  logic           flush_in,
  input  logic           disp_valid_in,
  output logic           disp_ready_out,
  input  sinst_t         disp_op_in,
  input  regtag_t        disp_tagx_in,
  input  regtag_t        disp_tagy_in,
  input  word_t          disp_datax_in,
  input  word_t          disp_datay_in,
  input  regtag_t        disp_dest_in,
  input  regaddr_t       disp_target_in,
  input  logic           cdb_en_in,
  input  regtag_t        cdb_tag_in,
  input  word_t          cdb_data_in,
  output logic           issue_valid_out,
  output sinst_t         issue_op_out,
  output word_t          issue_datax_out,
  output word_t          issue_datay_out,
  output regaddr_t       issue_target_out,
  output regtag_t        issue_dest_out,
  output logic [IDX_W:0] count_out
);

  logic [DEPTH-1:0] valid;
  entry_t           ent [DEPTH];
  logic [IDX_W:0]   count;
  logic [DEPTH-1:0] ready_vec;
  logic [DEPTH-1:0] alloc_oh;
  logic [DEPTH-1:0] alloc_en;
  logic [DEPTH-1:0] grant;
  logic [IDX_W-1:0] sel_idx;
  logic             accept;
  logic             issue;
  logic             kill;
  entry_t           disp_ent;

  assign kill           = rst_in || flush_in;
  assign disp_ready_out = (count < (IDX_W+1)'(DEPTH));
  assign accept         = disp_valid_in && disp_ready_out;
  assign issue          = |grant;
  assign alloc_en       = accept ? alloc_oh : '0;
  assign count_out      = count;

  always_comb begin
    ready_vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ready_vec[i] = valid[i] && operands_ready(ent[i]);
    end
  end

  always_comb begin
    alloc_oh = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid[i]) alloc_oh = DEPTH'(1) << i;
    end
  end

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (grant[i]) sel_idx = IDX_W'(i);
    end
  end

  // A tag broadcast in the dispatch cycle would otherwise be missed forever
  always_comb begin
    disp_ent = '{op: disp_op_in, tagx: disp_tagx_in, tagy: disp_tagy_in,
                 datax: disp_datax_in, datay: disp_datay_in,
                 dest: disp_dest_in, target: disp_target_in};
    if (cdb_en_in && (disp_tagx_in != UNLOCKED) && (disp_tagx_in == cdb_tag_in)) begin
      disp_ent.tagx  = UNLOCKED;
      disp_ent.datax = cdb_data_in;
    end
    if (cdb_en_in && (disp_tagy_in != UNLOCKED) && (disp_tagy_in == cdb_tag_in)) begin
      disp_ent.tagy  = UNLOCKED;
      disp_ent.datay = cdb_data_in;
    end
  end

  alu_rs_age #(.DEPTH(DEPTH)) u_age (
    .clk   (clk_in),
    .clr   (kill),
    .alloc (alloc_en),
    .free  (grant),
    .ready (ready_vec),
    .grant (grant)
  );

  always_ff @(posedge clk_in) begin
    if (kill) valid <= '0;
    else      valid <= (valid & ~grant) | alloc_en;
  end

  // NOTE: the payload array carries no reset; the valid bits alone decide
  // whether an entry's contents mean anything.
  always_ff @(posedge clk_in) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (alloc_en[i]) begin
        ent[i] <= disp_ent;
      end else if (cdb_en_in && valid[i]) begin
        if ((ent[i].tagx != UNLOCKED) && (ent[i].tagx == cdb_tag_in)) begin
          ent[i].tagx  <= UNLOCKED;
          ent[i].datax <= cdb_data_in;
        end
        if ((ent[i].tagy != UNLOCKED) && (ent[i].tagy == cdb_tag_in)) begin
          ent[i].tagy  <= UNLOCKED;
          ent[i].datay <= cdb_data_in;
        end
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (kill) begin
      issue_valid_out  <= 1'b0;
      issue_op_out     <= OP_ADD;
      issue_datax_out  <= '0;
      issue_datay_out  <= '0;
      issue_target_out <= '0;
      issue_dest_out   <= '0;
    end else begin
      issue_valid_out <= issue;
      if (issue) begin
        issue_op_out     <= ent[sel_idx].op;
        issue_datax_out  <= ent[sel_idx].datax;
        issue_datay_out  <= ent[sel_idx].datay;
        issue_target_out <= ent[sel_idx].target;
        issue_dest_out   <= ent[sel_idx].dest;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (kill) count <= '0;
    else      count <= count + (IDX_W+1)'(accept) - (IDX_W+1)'(issue);
  end

endmodule

// File: tb/tb_alu_rs.sv
// Self-checking bench for alu_rs: directed scenarios plus random traffic,
// compared against an in-order queue model of the station.
module tb_alu_rs;
  import alu_rs_pkg::*;

  localparam int DEPTH = 4;
  localparam int IDX_W = 2;

  logic           clk_in = 1'b0;
  logic           rst_in, flush_in, disp_valid_in, disp_ready_out;
  sinst_t         disp_op_in;
  regtag_t        disp_tagx_in, disp_tagy_in, disp_dest_in;
  word_t          disp_datax_in, disp_datay_in;
  regaddr_t       disp_target_in;
  logic           cdb_en_in;
  regtag_t        cdb_tag_in;
  word_t          cdb_data_in;
  logic           issue_valid_out;
  sinst_t         issue_op_out;
  word_t          issue_datax_out, issue_datay_out;
  regaddr_t       issue_target_out;
  regtag_t        issue_dest_out;
  logic [IDX_W:0] count_out;

  alu_rs #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .flush_in(flush_in),
    .disp_valid_in(disp_valid_in), .disp_ready_out(disp_ready_out),
    .disp_op_in(disp_op_in), .disp_tagx_in(disp_tagx_in), .disp_tagy_in(disp_tagy_in),
    .disp_datax_in(disp_datax_in), .disp_datay_in(disp_datay_in),
    .disp_dest_in(disp_dest_in), .disp_target_in(disp_target_in),
    .cdb_en_in(cdb_en_in), .cdb_tag_in(cdb_tag_in), .cdb_data_in(cdb_data_in),
    .issue_valid_out(issue_valid_out), .issue_op_out(issue_op_out),
    .issue_datax_out(issue_datax_out), .issue_datay_out(issue_datay_out),
    .issue_target_out(issue_target_out), .issue_dest_out(issue_dest_out),
    .count_out(count_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    sinst_t   op;
    regtag_t  tagx;
    regtag_t  tagy;
    word_t    datax;
    word_t    datay;
    regtag_t  dest;
    regaddr_t target;
  } ins_t;

  int     checks = 0;
  int     errors = 0;
  ins_t   mq[$];      // live instructions, oldest first
  logic   exp_iv;
  ins_t   exp_iss;
  ins_t   none;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic ins_t mk(input sinst_t op, input regtag_t tx, input regtag_t ty,
                              input word_t dx, input word_t dy, input regtag_t dest,
                              input regaddr_t tgt);
    ins_t n;
    n.op = op; n.tagx = tx; n.tagy = ty; n.datax = dx; n.datay = dy;
    n.dest = dest; n.target = tgt;
    return n;
  endfunction

  task automatic check_outputs();
    check("issue_valid", 32'(issue_valid_out), 32'(exp_iv));
    check("issue_op", 32'(issue_op_out), 32'(exp_iss.op));
    check("issue_datax", issue_datax_out, exp_iss.datax);
    check("issue_datay", issue_datay_out, exp_iss.datay);
    check("issue_target", 32'(issue_target_out), 32'(exp_iss.target));
    check("issue_dest", 32'(issue_dest_out), 32'(exp_iss.dest));
    check("count", 32'(count_out), 32'(mq.size()));
  endtask

  // One clock: drive, check ready, advance the model, then check outputs.
  task automatic cycle(input bit fl, input bit dv, input ins_t d,
                       input bit ce, input regtag_t ct, input word_t cd);
    bit   rdy;
    int   k;
    ins_t n;
    @(negedge clk_in);
    flush_in = fl; disp_valid_in = dv; cdb_en_in = ce; cdb_tag_in = ct; cdb_data_in = cd;
    disp_op_in = d.op; disp_tagx_in = d.tagx; disp_tagy_in = d.tagy;
    disp_datax_in = d.datax; disp_datay_in = d.datay;
    disp_dest_in = d.dest; disp_target_in = d.target;
    rdy = (mq.size() < DEPTH);
    #1 check("disp_ready", 32'(disp_ready_out), 32'(rdy));
    if (fl) begin
      mq.delete();
      exp_iv  = 1'b0;
      exp_iss = none;
    end else begin
      k = -1;
      for (int i = 0; i < mq.size(); i++)
        if (k < 0 && mq[i].tagx == UNLOCKED && mq[i].tagy == UNLOCKED) k = i;
      exp_iv = (k >= 0);
      if (k >= 0) begin
        exp_iss = mq[k];
        mq.delete(k);
      end
      if (ce && ct != UNLOCKED) begin
        for (int i = 0; i < mq.size(); i++) begin
          if (mq[i].tagx == ct) begin mq[i].tagx = UNLOCKED; mq[i].datax = cd; end
          if (mq[i].tagy == ct) begin mq[i].tagy = UNLOCKED; mq[i].datay = cd; end
        end
      end
      if (dv && rdy) begin
        n = d;
        if (ce && ct != UNLOCKED && n.tagx == ct) begin n.tagx = UNLOCKED; n.datax = cd; end
        if (ce && ct != UNLOCKED && n.tagy == ct) begin n.tagy = UNLOCKED; n.datay = cd; end
        mq.push_back(n);
      end
    end
    @(posedge clk_in);
    #1 check_outputs();
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, none, 1'b0, UNLOCKED, '0);
  endtask

  task automatic disp(input ins_t d);
    cycle(1'b0, 1'b1, d, 1'b0, UNLOCKED, '0);
  endtask

  task automatic bcast(input regtag_t t, input word_t v);
    cycle(1'b0, 1'b0, none, 1'b1, t, v);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    none = '0;
    rst_in = 1'b1; flush_in = 1'b0; disp_valid_in = 1'b0; cdb_en_in = 1'b0;
    cdb_tag_in = '0; cdb_data_in = '0; disp_op_in = OP_ADD;
    disp_tagx_in = '0; disp_tagy_in = '0; disp_datax_in = '0; disp_datay_in = '0;
    disp_dest_in = '0; disp_target_in = '0;
    repeat (2) @(posedge clk_in);
    #1;
    exp_iv = 1'b0; exp_iss = none;
    check_outputs();
    check("reset_ready", 32'(disp_ready_out), 32'd1);
    @(negedge clk_in);
    rst_in = 1'b0;

    // Both operands present: issues one edge after dispatch
    disp(mk(OP_ADD, UNLOCKED, UNLOCKED, 32'd5, 32'd7, 4'd3, 5'd9));
    check("t1_no_early_issue", 32'(issue_valid_out), 32'd0);
    idle();
    check("t1_valid", 32'(issue_valid_out), 32'd1);
    check("t1_datax", issue_datax_out, 32'd5);
    check("t1_datay", issue_datay_out, 32'd7);
    check("t1_dest", 32'(issue_dest_out), 32'd3);
    check("t1_count", 32'(count_out), 32'd0);

    // Operand x waits on tag 2, broadcast two cycles later
    disp(mk(OP_SUB, 4'd2, UNLOCKED, 32'd0, 32'd3, 4'd5, 5'd1));
    idle();
    bcast(4'd2, 32'h1234);
    check("t2_wait", 32'(issue_valid_out), 32'd0);
    idle();
    check("t2_valid", 32'(issue_valid_out), 32'd1);
    check("t2_datax", issue_datax_out, 32'h1234);
    idle();
    check("t2_hold", issue_datax_out, 32'h1234);

    // Dispatch and broadcast of the same tag in one cycle
    cycle(1'b0, 1'b1, mk(OP_OR, UNLOCKED, 4'd6, 32'd1, 32'd0, 4'd7, 5'd2), 1'b1, 4'd6, 32'd9);
    idle();
    check("t3_datay", issue_datay_out, 32'd9);
    check("t3_valid", 32'(issue_valid_out), 32'd1);

    // Fill, reject a fifth dispatch, then drain in dispatch order
    for (int k = 0; k < 4; k++)
      disp(mk(OP_XOR, 4'd1, UNLOCKED, '0, 32'(k), regtag_t'(10 + k), 5'(k)));
    check("t4_full", 32'(disp_ready_out), 32'd0);
    disp(mk(OP_AND, UNLOCKED, UNLOCKED, 32'd1, 32'd1, 4'd14, 5'd4));
    check("t4_count", 32'(count_out), 32'd4);
    bcast(4'd1, 32'hABCD);
    for (int k = 0; k < 4; k++) begin
      idle();
      check("t4_order", 32'(issue_dest_out), 32'(10 + k));
    end

    // Younger ready entry bypasses an older waiting one
    disp(mk(OP_SLT, 4'd4, UNLOCKED, '0, 32'd2, 4'd8, 5'd5));
    disp(mk(OP_SLL, UNLOCKED, UNLOCKED, 32'd3, 32'd4, 4'd9, 5'd6));
    idle();
    check("t5_young_first", 32'(issue_dest_out), 32'd9);
    bcast(4'd4, 32'd77);
    idle();
    check("t5_old_after", 32'(issue_dest_out), 32'd8);

    // Flush with three held entries, one ready; dispatch in flush cycle dropped
    disp(mk(OP_ADD, 4'd5, UNLOCKED, '0, '0, 4'd11, 5'd7));
    disp(mk(OP_ADD, 4'd5, UNLOCKED, '0, '0, 4'd12, 5'd8));
    disp(mk(OP_ADD, UNLOCKED, UNLOCKED, 32'd1, 32'd2, 4'd13, 5'd9));
    cycle(1'b1, 1'b1, mk(OP_SUB, UNLOCKED, UNLOCKED, 32'd4, 32'd4, 4'd15, 5'd10),
          1'b0, UNLOCKED, '0);
    check("t6_valid", 32'(issue_valid_out), 32'd0);
    check("t6_count", 32'(count_out), 32'd0);
    check("t6_ready", 32'(disp_ready_out), 32'd1);
    idle();

    // Random traffic with a small tag space so wakeups and bypasses collide
    for (int n = 0; n < 400; n++) begin
      ins_t d;
      d = mk(sinst_t'($urandom_range(0, 9)), regtag_t'($urandom_range(0, 3)),
             regtag_t'($urandom_range(0, 3)), $urandom, $urandom,
             regtag_t'($urandom_range(0, 15)), regaddr_t'($urandom_range(0, 31)));
      cycle(($urandom_range(0, 39) == 0), ($urandom_range(0, 1) == 1), d,
            ($urandom_range(0, 1) == 1), regtag_t'($urandom_range(0, 3)), $urandom);
    end

    // Reset in mid-operation discards everything
    disp(mk(OP_ADD, UNLOCKED, UNLOCKED, 32'd1, 32'd1, 4'd2, 5'd3));
    @(negedge clk_in);
    rst_in = 1'b1; disp_valid_in = 1'b0; cdb_en_in = 1'b0; flush_in = 1'b0;
    @(posedge clk_in);
    #1;
    mq.delete(); exp_iv = 1'b0; exp_iss = none;
    check_outputs();
    @(negedge clk_in);
    rst_in = 1'b0;
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
